// File: rtl/countdown_pkg.sv
// Shared types and helpers for the game round BCD countdown.
package countdown_pkg;

  localparam int BCD_W = 4;
  localparam logic [BCD_W-1:0] BCD_MAX = 4'd9;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RUN     = 2'd1,
    PAUSE   = 2'd2,
    EXPIRED = 2'd3
  } countdownState_e;

  function automatic logic [BCD_W-1:0] clampBcd(input logic [BCD_W-1:0] d);
    return (d > BCD_MAX) ? BCD_MAX : d;
  endfunction

endpackage

// File: rtl/bcd_down_digit.sv
// One loadable BCD down-counting digit; chained via borrowIn/borrowOut.
module bcd_down_digit
  import countdown_pkg::*;
#(
  parameter logic [BCD_W-1:0] RESET_VAL = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [BCD_W-1:0] loadValue,
  input  logic             dec,
  input  logic             borrowIn,
  output logic [BCD_W-1:0] digit,
  output logic             borrowOut
);

  assign borrowOut = (digit == '0) && borrowIn;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      digit <= RESET_VAL;
    end else if (load) begin
      digit <= clampBcd(loadValue);
    end else if (dec && borrowIn) begin
      digit <= (digit == '0) ? BCD_MAX : digit - 4'd1;
    end
  end

endmodule

// File: rtl/game_countdown_timer.sv
// Game round countdown (tens.ones.tenths BCD) driven by the 100 ms strobe.
// Optional low-time warning output enabled by defining COUNTDOWN_WARN_EN.
module game_countdown_timer
  import countdown_pkg::*;
#(
  parameter int DEFAULT_TENS = 6,
  parameter int DEFAULT_ONES = 0,
  parameter int WARN_SECONDS = 10
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             HundredmsTimeout,
  input  logic             load,
  input  logic [BCD_W-1:0] load_tens,
  input  logic [BCD_W-1:0] load_ones,
  input  logic             start,
  input  logic             pause,
  output logic             timer_enable,
  output logic [BCD_W-1:0] secs_tens,
  output logic [BCD_W-1:0] secs_ones,
  output logic [BCD_W-1:0] tenths,
  output logic             running,
  output logic             expired,
  output logic             expired_pulse,
  output logic             warn
);

  countdownState_e state, nextState;

  logic tenthsBorrow, onesBorrow, isZero;
  logic isOne, tickRun, decEn;

  if (WARN_SECONDS < 1 || WARN_SECONDS > 99) begin : gBadWarnSeconds
    $error("WARN_SECONDS must be in 1..99");
  end

  // Tens borrow-out with a constant borrow-in at tenths means the value is 00.0.
  assign isOne   = (secs_tens == '0) && (secs_ones == '0) && (tenths == 4'd1);
  assign tickRun = (state == RUN) && HundredmsTimeout && !load;
  assign decEn   = tickRun && !isZero;

  bcd_down_digit #(.RESET_VAL(4'd0)) uTenths (
    .clk(clk), .rst(rst), .load(load), .loadValue(4'd0), .dec(decEn),
    .borrowIn(1'b1), .digit(tenths), .borrowOut(tenthsBorrow)
  );

  bcd_down_digit #(.RESET_VAL(clampBcd(4'(DEFAULT_ONES)))) uOnes (
    .clk(clk), .rst(rst), .load(load), .loadValue(load_ones), .dec(decEn),
    .borrowIn(tenthsBorrow), .digit(secs_ones), .borrowOut(onesBorrow)
  );

  bcd_down_digit #(.RESET_VAL(clampBcd(4'(DEFAULT_TENS)))) uTens (
    .clk(clk), .rst(rst), .load(load), .loadValue(load_tens), .dec(decEn),
    .borrowIn(onesBorrow), .digit(secs_tens), .borrowOut(isZero)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= nextState;
  end

  always_comb begin
    nextState = state;
    if (load) begin
      nextState = IDLE;
    end else begin
      case (state)
        IDLE:    if (start && !isZero) nextState = RUN;
        RUN: begin
          if (tickRun && isOne) nextState = EXPIRED;
          else if (pause)       nextState = PAUSE;
        end
        PAUSE:   if (start && !pause) nextState = RUN;
        EXPIRED: nextState = EXPIRED;
        default: nextState = IDLE;
      endcase
    end
  end

  // Status flags are registered from nextState so they line up with the state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      timer_enable  <= 1'b0;
      running       <= 1'b0;
      expired       <= 1'b0;
      expired_pulse <= 1'b0;
    end else begin
      timer_enable  <= (nextState == RUN);
      running       <= (nextState == RUN);
      expired       <= (nextState == EXPIRED);
      expired_pulse <= (nextState == EXPIRED) && (state != EXPIRED);
    end
  end

`ifdef COUNTDOWN_WARN_EN
  logic [6:0] secsNow, secsNext;
  logic       warnNext;

  assign secsNow  = 7'(secs_tens) * 7'd10 + 7'(secs_ones);
  // Look at the post-decrement seconds so warn tracks the digits without lag.
  assign secsNext = (decEn && tenths == '0) ? secsNow - 7'd1 : secsNow;
  assign warnNext = ((nextState == RUN) || (nextState == PAUSE)) &&
                    (secsNext < 7'(WARN_SECONDS));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) warn <= 1'b0;
    else     warn <= warnNext;
  end
`else
  assign warn = 1'b0;
`endif

endmodule

// File: doc/game_countdown_timer.md
Name: game_countdown_timer

Overview:
- Downstream consumer of the 100 ms timeout strobe from the hundred-millisecond timer.
- Maintains a loadable BCD countdown (tens of seconds, seconds, tenths) for the game round.
- Drives the enable of the upstream 100 ms timer and flags expiry to the game controller and display logic.

Parameters:
- DEFAULT_TENS, 6, BCD tens digit loaded at reset.
- DEFAULT_ONES, 0, BCD ones digit loaded at reset.
- WARN_SECONDS, 10, threshold for the warning output (optional feature only), in whole seconds, range 1-99.

Ports:
- clk  input  1  system clock.
- rst  input  1  asynchronous, active-high reset.
- HundredmsTimeout  input  1  one-cycle strobe from the upstream 100 ms timer.
- load  input  1  load load_tens/load_ones; level-sampled each cycle.
- load_tens  input  4  BCD tens digit to load.
- load_ones  input  4  BCD ones digit to load.
- start  input  1  start or resume the countdown.
- pause  input  1  pause the countdown.
- timer_enable  output  1  enable for the upstream 100 ms timer.
- secs_tens  output  4  BCD tens-of-seconds remaining.
- secs_ones  output  4  BCD seconds remaining.
- tenths  output  4  BCD tenths remaining.
- running  output  1  high in RUN.
- expired  output  1  level; high in EXPIRED.
- expired_pulse  output  1  one-cycle strobe on entry to EXPIRED.
- warn  output  1  low-time warning (optional feature).

Behaviour:
- Clock and reset: one clock, clk. Reset is asynchronous and active-high on rst. All state is registered on the rising edge of clk.
- Reset values:
  - state = IDLE.
  - secs_tens = DEFAULT_TENS, secs_ones = DEFAULT_ONES, tenths = 0.
  - timer_enable, running, expired, expired_pulse and warn all 0.
- FSM states: IDLE, RUN, PAUSE, EXPIRED.
- Input priority per cycle: rst > load > start/pause > tick.
- load (any state):
  - Digits take load_tens and load_ones; any digit above 9 is clamped to 9.
  - tenths = 0; next state = IDLE.
  - start, pause and tick are ignored that cycle.
- IDLE:
  - start with a nonzero value -> RUN.
  - start with value 00.0 -> remain IDLE.
  - pause is ignored.
- RUN:
  - Each HundredmsTimeout decrements the value by 0.1 s.
  - Borrow chain: tenths 0 -> 9 with borrow into ones; ones 0 -> 9 with borrow into tens.
  - When a decrement produces 00.0, next state = EXPIRED. The digits hold at 00.0 and never wrap to 99.9.
  - pause -> PAUSE. A tick arriving in the same cycle as pause is still applied.
  - Tick and pause in the same cycle that reaches 00.0: EXPIRED wins.
  - start is ignored.
- PAUSE:
  - start -> RUN. Ticks are ignored.
  - If start and pause are both high, pause wins and the block stays in PAUSE.
- EXPIRED:
  - Holds until load or rst; start and pause are ignored.
  - expired_pulse is high only on the first cycle in EXPIRED.
- Registered outputs, valid the cycle after the state register updates:
  - timer_enable = (next state == RUN).
  - running = (state == RUN).
  - expired = (state == EXPIRED).
- Latency:
  - tick to digit update: 1 cycle.
  - start to timer_enable high: 1 cycle.
- Tick sampling: HundredmsTimeout is sampled only in RUN, so a strobe coincident with the transition into RUN is ignored.

Optional Feature:
- Macro: COUNTDOWN_WARN_EN.
- Defined:
  - warn is registered and goes high in RUN or PAUSE while remaining time < WARN_SECONDS, i.e. (tens*10 + ones) < WARN_SECONDS.
  - warn clears on load, rst, or entry to EXPIRED.
- Not defined: warn is tied to 0 and no comparator logic exists.

Decomposition:
- Package countdown_pkg:
  - State enum (IDLE=2'd0, RUN=2'd1, PAUSE=2'd2, EXPIRED=2'd3).
  - BCD_W = 4 and BCD_MAX = 4'd9.
  - Clamp function for BCD digits.
- Sub-module bcd_down_digit:
  - One BCD digit with load, decrement-enable, borrow_in and borrow_out (borrow_out = digit==0 && borrow_in).
  - Instantiated three times in a chain; the FSM stays in the top level.

Test Plan:
- Hold after reset: rst, then no inputs -> digits 6,0,0; state IDLE; timer_enable 0; held for 1000 cycles.
- Load and tick: load 0x1/0x2, start, 3 ticks -> 12.0 -> 11.9 -> 11.8 -> 11.7. timer_enable goes high 1 cycle after start.
- Borrow chain and expiry: load 1,0, start, 1 tick -> 09.9. Continue to 100 ticks total -> 00.0, expired_pulse high for exactly 1 cycle, expired held. Further ticks and start produce no change.
- Pause semantics:
  - pause with a coincident tick at 05.3 -> 05.2 and state PAUSE.
  - 5 ticks while paused -> still 05.2.
  - start -> RUN.
  - start and pause asserted together while in PAUSE -> stays PAUSE.
- Load edge cases:
  - load 0xC/0x3 -> clamped to 93.0.
  - load 0,0 then start -> remains IDLE, timer_enable 0.
  - load during RUN -> IDLE with the new value.
- Async reset and warning:
  - rst asserted mid-RUN between clock edges -> outputs reset immediately.
  - With COUNTDOWN_WARN_EN and WARN_SECONDS=10: warn low at 10.0, high at 09.9, low after expiry.
